layer_output_collector: RTL and testbench

//  Sits directly downstream of a layer of parallel neuron instances. Captures each

---
 rtl/layer_output_collector_if.sv | 67 ++++++
 rtl/layer_output_collector.sv | 154 +++++++++++++++
 tb/tb_layer_output_collector.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_output_collector_if.sv
// layer_output_collector_if
//   Bundles the signals between a layer of parallel neurons, the output collector
//   and the next layer's input stream.
//   Optional macro: ARGMAX_EN adds argmax_idx / argmax_valid.
//   Signals:
//     neuron_out_bus    neuron n output at [n*DataWidth +: DataWidth]
//     neuron_out_valid  per-neuron valid
//     layer_start       rearm pulse, honoured only after a finished stream
//     data_out          serialized value for the next layer
//     data_out_valid    data_out valid
//     data_out_ready    downstream accepts data_out this cycle
//     data_out_idx      neuron index of data_out
//     layer_done        1-cycle pulse after the last transfer
//     argmax_idx        (ARGMAX_EN) index of the largest output
//     argmax_valid      (ARGMAX_EN) argmax_idx is final
//   Modports: master = collector, slave = its environment.
interface layer_output_collector_if #(
    parameter int unsigned NumNeurons = 32,
    parameter int unsigned DataWidth  = 16
);
    localparam int unsigned IdxWidth = $clog2(NumNeurons);

    logic [NumNeurons*DataWidth-1:0] neuron_out_bus;
    logic [NumNeurons-1:0]           neuron_out_valid;
    logic                            layer_start;
    logic [DataWidth-1:0]            data_out;
    logic                            data_out_valid;
    logic                            data_out_ready;
    logic [IdxWidth-1:0]             data_out_idx;
    logic                            layer_done;
`ifdef ARGMAX_EN
    logic [IdxWidth-1:0]             argmax_idx;
    logic                            argmax_valid;
`endif

    modport master (
        input  neuron_out_bus,
        input  neuron_out_valid,
        input  layer_start,
        input  data_out_ready,
        output data_out,
        output data_out_valid,
        output data_out_idx,
        output layer_done
`ifdef ARGMAX_EN
        ,
        output argmax_idx,
        output argmax_valid
`endif
    );

    modport slave (
        output neuron_out_bus,
        output neuron_out_valid,
        output layer_start,
        output data_out_ready,
        input  data_out,
        input  data_out_valid,
        input  data_out_idx,
        input  layer_done
`ifdef ARGMAX_EN
        ,
        input  argmax_idx,
        input  argmax_valid
`endif
    );
endinterface

// File: rtl/layer_output_collector.sv
// layer_output_collector
//   Captures the first value each neuron of a layer presents, then streams all
//   NumNeurons values in index order over a valid/ready handshake, followed by a
//   one-cycle layer_done pulse. Data passes bit-exact.
//   Optional macro: ARGMAX_EN tracks the index of the largest (signed) value while
//   streaming; ties keep the lowest index.
//   Ports:
//     clk    clock, posedge
//     reset  synchronous, active-low
//     bus    layer_output_collector_if.master (neuron inputs, output stream, argmax)
module layer_output_collector #(
    parameter int unsigned NumNeurons = 32,
    parameter int unsigned DataWidth  = 16
) (
    input logic                      clk,
    input logic                      reset,
    layer_output_collector_if.master bus
);
    localparam int unsigned         IdxWidth = $clog2(NumNeurons);
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumNeurons - 1);

    typedef enum logic [1:0] {StCollect, StStream, StDone} state_e;

    state_e                state_q, state_d;
    logic [NumNeurons-1:0] flags_q, flags_d;
    logic [DataWidth-1:0]  buffer_q [NumNeurons];
    logic [IdxWidth-1:0]   idx_q, idx_d;
    logic                  layer_done_q, layer_done_d;

    logic [NumNeurons-1:0] capture;
    logic                  all_captured;
    logic                  transfer;
    logic                  last_transfer;
    logic [DataWidth-1:0]  cur_val;

    // First value wins: a neuron is captured only while its flag is still clear.
    assign capture       = (state_q == StCollect) ? (bus.neuron_out_valid & ~flags_q) : '0;
    // Counts flags being set this cycle so the stream starts on the next cycle.
    assign all_captured  = &(flags_q | capture);
    assign transfer      = (state_q == StStream) && bus.data_out_ready;
    assign last_transfer = transfer && (idx_q == LastIdx);
    assign cur_val       = buffer_q[idx_q];

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StCollect;
            flags_q      <= '0;
            idx_q        <= '0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            idx_q        <= idx_d;
            layer_done_q <= layer_done_d;
        end
    end

    // Result buffer needs no reset: it is only visible once every flag is set.
    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < NumNeurons; n++) begin
            if (capture[n]) begin
                buffer_q[n] <= bus.neuron_out_bus[n*DataWidth +: DataWidth];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        flags_d      = flags_q | capture;
        idx_d        = idx_q;
        layer_done_d = 1'b0;
        unique case (state_q)
            StCollect: begin
                if (all_captured) begin
                    state_d = StStream;
                    idx_d   = '0;
                end
            end
            StStream: begin
                if (transfer) begin
                    if (idx_q == LastIdx) begin
                        state_d      = StDone;
                        idx_d        = '0;
                        layer_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxWidth'(1);
                    end
                end
            end
            StDone: begin
                if (bus.layer_start) begin
                    state_d = StCollect;
                    flags_d = '0;
                end
            end
            default: state_d = StCollect;
        endcase
    end

`ifdef ARGMAX_EN
    logic [DataWidth-1:0] max_val_q, max_val_d;
    logic [IdxWidth-1:0]  max_idx_q, max_idx_d;
    logic [IdxWidth-1:0]  argmax_idx_q, argmax_idx_d;
    logic                 argmax_valid_q, argmax_valid_d;
    logic                 take_cur;

    always_ff @(posedge clk) begin
        if (!reset) begin
            max_val_q      <= '0;
            max_idx_q      <= '0;
            argmax_idx_q   <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            max_val_q      <= max_val_d;
            max_idx_q      <= max_idx_d;
            argmax_idx_q   <= argmax_idx_d;
            argmax_valid_q <= argmax_valid_d;
        end
    end

    // Index 0 seeds the running max; strictly greater replaces so ties keep the lower index.
    always_comb begin
        take_cur       = (idx_q == '0) || ($signed(cur_val) > $signed(max_val_q));
        max_val_d      = max_val_q;
        max_idx_d      = max_idx_q;
        argmax_idx_d   = argmax_idx_q;
        argmax_valid_d = argmax_valid_q;
        if (transfer && take_cur) begin
            max_val_d = cur_val;
            max_idx_d = idx_q;
        end
        if (last_transfer) begin
            argmax_idx_d   = take_cur ? idx_q : max_idx_q;
            argmax_valid_d = 1'b1;
        end else if ((state_q == StDone) && bus.layer_start) begin
            argmax_valid_d = 1'b0;
        end
    end
`endif

    // Outputs
    always_comb begin
        bus.data_out_valid = (state_q == StStream);
        bus.data_out       = (state_q == StStream) ? cur_val : '0;
        bus.data_out_idx   = idx_q;
        bus.layer_done     = layer_done_q;
`ifdef ARGMAX_EN
        bus.argmax_idx     = argmax_idx_q;
        bus.argmax_valid   = argmax_valid_q;
`endif
    end
endmodule

// File: tb/tb_layer_output_collector.sv
// tb_layer_output_collector
//   Bench for layer_output_collector with 4 neurons of 16 bits. A small model keeps
//   first-wins captures and pushes the expected stream into a scoreboard queue once
//   every neuron is captured; outputs are popped and compared on each transfer.
//   Optional macro: ARGMAX_EN enables the argmax comparisons.
module tb_layer_output_collector;
    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned IW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    layer_output_collector_if #(.NumNeurons(N), .DataWidth(W)) bus ();

    layer_output_collector #(.NumNeurons(N), .DataWidth(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [W-1:0]  data;
        logic [IW-1:0] idx;
    } exp_t;

    typedef struct {
        logic [N-1:0]   vmask [4];
        logic [N*W-1:0] busv  [4];
        logic [N-1:0]   stall;
    } vec_t;

    int checks = 0;
    int errors = 0;

    exp_t         sb[$];
    logic [W-1:0] m_buf [N];
    logic [N-1:0] m_flag;
    bit           m_collect;
    vec_t         vecs [3];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int model_argmax();
        int best = 0;
        for (int i = 1; i < int'(N); i++) begin
            if ($signed(m_buf[i]) > $signed(m_buf[best])) best = i;
        end
        return best;
    endfunction

    // Present one cycle of neuron valids/values and update the model.
    task automatic drive(input logic [N-1:0] vmask, input logic [N*W-1:0] busv);
        exp_t e;
        @(negedge clk);
        if (m_collect) check("no_output_while_collecting", bus.data_out_valid, 0);
        bus.neuron_out_valid = vmask;
        bus.neuron_out_bus   = busv;
        if (m_collect) begin
            for (int n = 0; n < int'(N); n++) begin
                if (vmask[n] && !m_flag[n]) begin
                    m_flag[n] = 1'b1;
                    m_buf[n]  = busv[n*W +: W];
                end
            end
            if (&m_flag) begin
                for (int n = 0; n < int'(N); n++) begin
                    e.data = m_buf[n];
                    e.idx  = IW'(n);
                    sb.push_back(e);
                end
                m_collect = 1'b0;
            end
        end
    endtask

    // Accept max_xfers transfers, holding ready low once on each index set in stall.
    task automatic drain(input logic [N-1:0] stall, input int max_xfers,
                         input bit start_in_stream);
        int xfers = 0;
        int k;
        bit hold;
        bit started = 1'b0;
        bit stalled [N];
        for (int i = 0; i < int'(N); i++) stalled[i] = 1'b0;
        for (int cyc = 0; cyc < 40 && xfers < max_xfers; cyc++) begin
            @(negedge clk);
            bus.layer_start = 1'b0;
            check("no_done_mid_stream", bus.layer_done, 0);
            if (bus.data_out_valid) begin
                k    = int'(bus.data_out_idx);
                hold = stall[k] && !stalled[k];
                if (start_in_stream && !started) begin
                    bus.layer_start = 1'b1;
                    started         = 1'b1;
                end
                bus.data_out_ready = !hold;
                if (sb.size() == 0) begin
                    check("unexpected_output", bus.data_out_valid, 0);
                end else begin
                    check("stream_data", bus.data_out, sb[0].data);
                    check("stream_idx", bus.data_out_idx, sb[0].idx);
                    if (!hold) begin
                        void'(sb.pop_front());
                        xfers++;
                    end else begin
                        stalled[k] = 1'b1;
                    end
                end
            end else begin
                bus.data_out_ready = 1'b1;
            end
        end
        if (xfers < max_xfers) check("stream_timeout", xfers, max_xfers);
    endtask

    task automatic finish_stream();
        @(negedge clk);
        bus.layer_start = 1'b0;
        check("layer_done_pulse", bus.layer_done, 1);
        check("valid_low_after_last", bus.data_out_valid, 0);
        check("idx_wrapped", bus.data_out_idx, 0);
`ifdef ARGMAX_EN
        check("argmax_valid", bus.argmax_valid, 1);
        check("argmax_idx", bus.argmax_idx, model_argmax());
`endif
        @(negedge clk);
        check("layer_done_one_cycle", bus.layer_done, 0);
`ifdef ARGMAX_EN
        check("argmax_valid_held", bus.argmax_valid, 1);
`endif
    endtask

    task automatic restart();
        @(negedge clk);
        bus.neuron_out_valid = '0;
        bus.layer_start      = 1'b1;
        @(negedge clk);
        bus.layer_start = 1'b0;
        check("idle_after_start", bus.data_out_valid, 0);
`ifdef ARGMAX_EN
        check("argmax_valid_cleared", bus.argmax_valid, 0);
`endif
        m_flag    = '0;
        m_collect = 1'b1;
    endtask

    initial begin
        bus.neuron_out_bus   = '0;
        bus.neuron_out_valid = '0;
        bus.layer_start      = 1'b0;
        bus.data_out_ready   = 1'b1;
        m_flag               = '0;
        m_collect            = 1'b1;

        // Separate-cycle arrival in order 2,0,3,1
        vecs[0].vmask = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
        vecs[0].busv  = '{{16'hFC00, 16'h0400, 16'h0001, 16'h0800},
                          {16'hFC00, 16'h0400, 16'h0001, 16'h0800},
                          {16'hFC00, 16'h0400, 16'h0001, 16'h0800},
                          {16'hFC00, 16'h0400, 16'h0001, 16'h0800}};
        vecs[0].stall = 4'b0000;
        // Ready low once at idx 1 and idx 2
        vecs[1].vmask = '{4'b0011, 4'b1100, 4'b0000, 4'b0000};
        vecs[1].busv  = '{{16'h7FFF, 16'h8000, 16'h1234, 16'h0000},
                          {16'h7FFF, 16'h8000, 16'h1234, 16'h0000},
                          {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                          {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        vecs[1].stall = 4'b0110;
        // Tie on 0x0300 with re-asserted valids carrying larger values
        vecs[2].vmask = '{4'b0011, 4'b0111, 4'b1000, 4'b0000};
        vecs[2].busv  = '{{16'h1111, 16'h2222, 16'h0300, 16'h0100},
                          {16'h1111, 16'h0300, 16'h7FFF, 16'h7FFF},
                          {16'hF000, 16'h7FFF, 16'h7FFF, 16'h7FFF},
                          {16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        vecs[2].stall = 4'b1001;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", bus.data_out_valid, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_idx", bus.data_out_idx, 0);
        check("rst_done", bus.layer_done, 0);
`ifdef ARGMAX_EN
        check("rst_argmax_idx", bus.argmax_idx, 0);
        check("rst_argmax_valid", bus.argmax_valid, 0);
`endif
        reset = 1'b1;

        foreach (vecs[v]) begin
            for (int s = 0; s < 4 && m_collect; s++) drive(vecs[v].vmask[s], vecs[v].busv[s]);
            @(posedge clk);
            #1 bus.neuron_out_valid = '0;
            drain(vecs[v].stall, 4, 1'b0);
            finish_stream();
            restart();
        end

        // All valids in one cycle, then held high with new values; layer_start in stream
        drive(4'b1111, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
        @(posedge clk);
        #1 bus.neuron_out_bus = {16'h7FFF, 16'h7FFE, 16'h7FFD, 16'h7FFC};
        drain(4'b0000, 4, 1'b1);
        finish_stream();
        restart();

        // Reset after two transfers aborts the stream
        drive(4'b1111, {16'hA004, 16'h5003, 16'hC002, 16'h0F01});
        @(posedge clk);
        #1 bus.neuron_out_valid = '0;
        drain(4'b0000, 2, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid", bus.data_out_valid, 0);
        check("abort_data", bus.data_out, 0);
        check("abort_idx", bus.data_out_idx, 0);
        check("abort_no_done", bus.layer_done, 0);
        @(negedge clk);
        check("abort_no_done_later", bus.layer_done, 0);
        reset = 1'b1;
        sb.delete();
        m_flag    = '0;
        m_collect = 1'b1;

        // Fresh collection after release streams all four new values
        drive(4'b1010, {16'h0040, 16'h0030, 16'hFFF0, 16'h0010});
        drive(4'b0101, {16'h0040, 16'h0030, 16'hFFF0, 16'h0010});
        @(posedge clk);
        #1 bus.neuron_out_valid = '0;
        drain(4'b0000, 4, 1'b0);
        finish_stream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
